btn_event_arbiter: RTL and testbench
====================================

// Module: btn_event_arbiter
// PURPOSE
//  Turns the four raw calculator buttons (add, sub, multiply, =) into clean one-per-press events.
//  Each button is synchronised and debounced; each release->press transition becomes one event.
//  Simultaneous events are arbitrated round-robin into a small FIFO.
//  The FIFO head is exposed to the CPU through the memory-mapped IO block, so no press is lost between CPU polls.
// PARAMETERS
//  N_BTN       4        number of buttons (index 0..N_BTN-1)
//  DB_CYCLES   1000000  consecutive clk cycles of stable level needed to accept a change (10 ms @100 MHz)
//  CNT_W       20       debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
//  FIFO_DEPTH  4        event FIFO entries (power of 2)
// PORTS
//  clk         in   1              system clock, all state on rising edge
//  reset_n     in   1              asynchronous, active-low reset
//  btn_raw     in   N_BTN          raw asynchronous button levels, 1 = pressed
//  evt_pop     in   1              1-cycle strobe: CPU consumed the head event
//  ovf_clr     in   1              1-cycle strobe: clear sticky overflow flag
//  evt_valid   out  1              FIFO non-empty
//  evt_code    out  clog2(N_BTN)   button index of the FIFO head; 0 when empty
//  evt_count   out  clog2(FIFO_DEPTH)+1   number of queued events
//  overflow    out  1              sticky: a press was coalesced and lost
// BEHAVIOUR
//  Reset (reset_n=0, async): sync flops, debounced state, counters, pending bits, FIFO pointers,
//   round-robin pointer and overflow all go to 0. Outputs read evt_valid=0, evt_code=0, evt_count=0, overflow=0.
//  Sync: two-flop synchroniser per button. Only sync[1] is used downstream.
//  Debounce, per button:
//   - Counter is cleared whenever sync==stable.
//   - Otherwise it increments each cycle. On the edge where it would reach DB_CYCLES, stable<=sync and counter<=0.
//   - Glitches shorter than DB_CYCLES never change stable.
//  Press detect: a stable 0->1 transition sets pending[i] on the next edge. 1->0 transitions generate nothing.
//   - A button held through reset deasserting produces exactly one event once debounced.
//  Arbitration:
//   - Each cycle with pending!=0 and push allowed, grant one index.
//   - Search starts at rr_ptr and wraps modulo N_BTN. The first pending index found is granted.
//   - On grant: pending[g]<=0, FIFO writes g, rr_ptr<=(g+1)%N_BTN.
//  Push allowed when evt_count<FIFO_DEPTH, or when a pop is accepted in the same cycle. At most one push per cycle.
//  Pop accepted when evt_pop && evt_valid. A pop while empty is ignored: no pointer change, no error.
//  Simultaneous push+pop: count unchanged, head advances, new entry goes to the tail.
//  Full FIFO: pending bits hold their requests and nothing is dropped.
//   - A new press on a button whose pending bit is already 1 sets overflow<=1. That press is coalesced.
//  overflow clears only via ovf_clr or reset. If ovf_clr and a new overflow occur in the same cycle, set wins.
//  Latency (no contention, FIFO not full), counted in edges from the first edge sampling btn_raw=1:
//   2 sync + DB_CYCLES debounce + 1 pending + 1 FIFO write, then evt_valid=1.
//  evt_code and evt_count are registered state (FIFO head/count) and update on the edge after push/pop.
//  Reset asserted mid-operation: queued events, pending presses and overflow are discarded immediately.
// TESTING (bench uses DB_CYCLES=4)
//  1. Clean press: btn_raw[2]=1 for 12 cycles -> evt_valid=1, evt_code=2, evt_count=1 after 8 edges.
//     Then evt_pop -> evt_valid=0 next edge, and no event on release.
//  2. Bounce: btn_raw[1] toggled every 2 cycles for 20 cycles, then held 0 -> evt_valid stays 0, pending stays 0.
//  3. Round-robin: after a lone btn0 event (rr_ptr=1), press btn0 and btn3 in the same cycle
//     -> FIFO receives 3 then 0 on consecutive edges, evt_count=3.
//  4. Full/overflow: 4 presses with no pop -> evt_count=4. 5th press on btn1 -> pending[1]=1, count stays 4.
//     Another btn1 press -> overflow=1. One evt_pop -> btn1 event pushed, count back to 4.
//     ovf_clr -> overflow=0.
//  5. Empty pop / simultaneous: evt_pop with FIFO empty -> no change.
//     At count=4, evt_pop on the same edge a pending event is granted -> count stays 4, head advances.
//  6. Reset mid-operation: evt_count=3, overflow=1, reset_n=0 between edges
//     -> immediately evt_valid=0, evt_count=0, overflow=0. btn_raw[0] held through release -> one event, code 0.

Source files
------------

// File: rtl/btn_event_arbiter_if.sv
// btn_event_arbiter_if: button/event bus between the CPU-side IO block (master) and the arbiter (slave)
interface btn_event_arbiter_if #(
  parameter int N_BTN      = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(N_BTN);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [N_BTN-1:0] btn_raw;
  logic             evt_pop;
  logic             ovf_clr;
  logic             evt_valid;
  logic [CW-1:0]    evt_code;
  logic [AW:0]      evt_count;
  logic             overflow;
  modport master (output btn_raw, evt_pop, ovf_clr, input evt_valid, evt_code, evt_count, overflow);
  modport slave  (input btn_raw, evt_pop, ovf_clr, output evt_valid, evt_code, evt_count, overflow);
endinterface

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: sync + debounce buttons, one event per press, round-robin into an event FIFO
module btn_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                reset_n,
  btn_event_arbiter_if.slave bus
);
  localparam int CW = $clog2(N_BTN);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [N_BTN-1:0] sync0_q, sync1_q, stable_q, stable_d, prev_q, pending_q, pending_d, rise, gmask;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [CW-1:0]    rr_q, rr_d, g, idx;
  logic [CW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q, count_d;
  logic             found, pop, push, ovf_q, ovf_d;
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync1_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) stable_d[i] = sync1_q[i];
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end
  assign rise = stable_q & ~prev_q;
  // first pending index at or after rr_q, wrapping
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = CW'((int'(rr_q) + k) % N_BTN);
      if (!found && pending_q[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end
  assign pop       = bus.evt_pop && (count_q != '0);
  assign push      = found && ((count_q != (AW+1)'(FIFO_DEPTH)) || pop);
  assign gmask     = push ? (N_BTN'(1) << g) : '0;
  assign pending_d = (pending_q & ~gmask) | rise;
  assign rr_d      = push ? ((g == CW'(N_BTN - 1)) ? '0 : g + CW'(1)) : rr_q;
  assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
  // a press landing on a still-queued request is lost; set beats clear
  assign ovf_d     = (|(rise & pending_q & ~gmask)) ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync0_q   <= bus.btn_raw;
      sync1_q   <= sync0_q;
      stable_q  <= stable_d;
      prev_q    <= stable_q;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      wr_q      <= push ? wr_q + AW'(1) : wr_q;
      rd_q      <= pop ? rd_q + AW'(1) : rd_q;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= g;
  end
  assign bus.evt_valid = count_q != '0;
  assign bus.evt_code  = bus.evt_valid ? mem_q[rd_q] : '0;
  assign bus.evt_count = count_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed scenarios with a scoreboard of expected event codes
module tb_btn_event_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [1:0] exp_q [$];
  btn_event_arbiter_if #(.N_BTN(4), .FIFO_DEPTH(4)) bus ();
  btn_event_arbiter #(.N_BTN(4), .DB_CYCLES(4), .CNT_W(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [3:0] m);
    bus.btn_raw = m;
    step(8);
    bus.btn_raw = '0;
    step(8);
  endtask
  task automatic pop_chk(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
    chk({tag, "_code"}, 32'(bus.evt_code), 32'(e));
    bus.evt_pop = 1'b1;
    step(1);
    bus.evt_pop = 1'b0;
  endtask
  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_chk(tag);
  endtask
  initial begin
    reset_n     = 1'b0;
    bus.btn_raw = '0;
    bus.evt_pop = 1'b0;
    bus.ovf_clr = 1'b0;
    step(2);
    chk("rst_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_code", 32'(bus.evt_code), 32'd0);
    chk("rst_count", 32'(bus.evt_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    reset_n = 1'b1;
    step(2);
    // 1: clean press, exact latency, no event on release
    bus.btn_raw = 4'b0100;
    exp_q.push_back(2'd2);
    step(7);
    chk("t1_valid_early", 32'(bus.evt_valid), 32'd0);
    step(1);
    chk("t1_valid", 32'(bus.evt_valid), 32'd1);
    chk("t1_count", 32'(bus.evt_count), 32'd1);
    step(4);
    bus.btn_raw = '0;
    step(10);
    chk("t1_release", 32'(bus.evt_count), 32'd1);
    pop_chk("t1_pop");
    chk("t1_empty", 32'(bus.evt_valid), 32'd0);
    // 2: bounce shorter than debounce window
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      step(2);
    end
    bus.btn_raw = '0;
    step(10);
    chk("t2_valid", 32'(bus.evt_valid), 32'd0);
    chk("t2_pending", 32'(dut.pending_q), 32'd0);
    // 3: round-robin from rr_ptr=1: btn3 wins over btn0
    press(4'b0001);
    exp_q.push_back(2'd0);
    bus.btn_raw = 4'b1001;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    step(8);
    chk("t3_count_a", 32'(bus.evt_count), 32'd2);
    step(1);
    chk("t3_count_b", 32'(bus.evt_count), 32'd3);
    step(3);
    bus.btn_raw = '0;
    step(8);
    drain("t3_pop");
    // 4: fill, hold pending, overflow, simultaneous push+pop
    for (int b = 0; b < 4; b++) begin
      press(4'(1 << b));
      exp_q.push_back(2'(b));
    end
    chk("t4_full", 32'(bus.evt_count), 32'd4);
    press(4'b0010);
    chk("t4_hold_count", 32'(bus.evt_count), 32'd4);
    chk("t4_pending", 32'(dut.pending_q), 32'b0010);
    chk("t4_no_ovf", 32'(bus.overflow), 32'd0);
    press(4'b0010);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    pop_chk("t4_pop");
    exp_q.push_back(2'd1);
    chk("t4_count_same", 32'(bus.evt_count), 32'd4);
    chk("t4_head_adv", 32'(bus.evt_code), 32'd1);
    chk("t4_pending_clr", 32'(dut.pending_q), 32'd0);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(bus.overflow), 32'd0);
    drain("t4_drain");
    // 5: pop while empty is ignored
    bus.evt_pop = 1'b1;
    step(1);
    bus.evt_pop = 1'b0;
    step(1);
    chk("t5_count", 32'(bus.evt_count), 32'd0);
    chk("t5_valid", 32'(bus.evt_valid), 32'd0);
    chk("t5_wr_after", 32'(dut.rd_q), 32'(dut.wr_q));
    // 6: async reset mid-operation, then a button held through reset
    for (int b = 0; b < 4; b++) begin
      press(4'(1 << b));
      exp_q.push_back(2'(b));
    end
    press(4'b0001);
    press(4'b0001);
    pop_chk("t6_pop_a");
    exp_q.push_back(2'd0);
    pop_chk("t6_pop_b");
    chk("t6_count", 32'(bus.evt_count), 32'd3);
    chk("t6_ovf", 32'(bus.overflow), 32'd1);
    bus.btn_raw = 4'b0001;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.evt_valid), 32'd0);
    chk("t6_rst_count", 32'(bus.evt_count), 32'd0);
    chk("t6_rst_ovf", 32'(bus.overflow), 32'd0);
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    step(10);
    exp_q.push_back(2'd0);
    chk("t6_held_count", 32'(bus.evt_count), 32'd1);
    pop_chk("t6_held_pop");
    bus.btn_raw = '0;
    step(10);
    chk("t6_single", 32'(bus.evt_count), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
